cache_tag_lookup: RTL

CACHE_TAG_LOOKUP -- requirements
Module: cache_tag_lookup

---
 rtl/cache_tag_lookup_pkg.sv | 14 +
 rtl/cache_tag_lookup.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_lookup_pkg.sv
// Geometry constants for the set-associative tag lookup block at its default configuration.
// Port widths of cache_tag_lookup are taken from here so producers and consumers agree.
package cache_tag_lookup_pkg;

  localparam int unsigned def_i_size = 64;
  localparam int unsigned def_d_size = 6;
  localparam int unsigned def_c_size = 14;
  localparam int unsigned def_a_size = 8;

  localparam int unsigned way_bits   = $clog2(def_a_size);
  localparam int unsigned index_bits = def_c_size - def_d_size - way_bits;
  localparam int unsigned tag_bits   = def_i_size - index_bits - def_d_size;

endpackage

// File: rtl/cache_tag_lookup.sv
// Set-associative tag array with tree pseudo-LRU replacement, dirty tracking and
// hit/miss counters. One request in flight; a response is held until it is accepted.
module cache_tag_lookup
  import cache_tag_lookup_pkg::index_bits, cache_tag_lookup_pkg::tag_bits;
#(
  parameter int unsigned i_size = cache_tag_lookup_pkg::def_i_size,
  parameter int unsigned d_size = cache_tag_lookup_pkg::def_d_size,
  parameter int unsigned c_size = cache_tag_lookup_pkg::def_c_size,
  parameter int unsigned a_size = cache_tag_lookup_pkg::def_a_size
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [tag_bits-1:0]       req_tag,
  input  logic [index_bits-1:0]     req_index,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_hit,
  output logic [$clog2(a_size)-1:0] resp_way,
  output logic                      resp_wb,
  output logic [tag_bits-1:0]       resp_wb_tag,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int unsigned way_bits = $clog2(a_size);
  localparam int unsigned nsets    = 1 << index_bits;

  if ((c_size - d_size - way_bits != index_bits) ||
      (i_size - index_bits - d_size != tag_bits)) begin : g_cfg_mismatch
    $error("cache_tag_lookup: parameters disagree with cache_tag_lookup_pkg widths");
  end

  typedef enum logic [2:0] {StInit, StIdle, StLookup, StUpdate, StResp} state_e;

  state_e state_q, state_d;
  logic [index_bits-1:0] init_idx_q, init_idx_d;

  logic [1:0]            op_q;
  logic [tag_bits-1:0]   tag_q;
  logic [index_bits-1:0] index_q;
  logic                  is_write;

  // Per-set storage; plru nodes use 1-based heap numbering (children of n are 2n, 2n+1).
  logic [a_size-1:0]   valid_q [nsets];
  logic [a_size-1:0]   dirty_q [nsets];
  logic [tag_bits-1:0] tags_q  [nsets][a_size];
  logic [a_size-1:1]   plru_q  [nsets];

  logic [a_size-1:0]   set_valid, set_dirty;
  logic [a_size-1:1]   set_plru;
  logic                lk_hit, inv_found, lk_wb;
  logic [way_bits-1:0] hit_way, inv_way, plru_way, lk_way;
  logic [tag_bits-1:0] lk_wb_tag;
  logic [way_bits:0]   node;

  logic                lk_hit_q, lk_wb_q;
  logic [way_bits-1:0] lk_way_q;
  logic [tag_bits-1:0] lk_wb_tag_q;

  logic                resp_hit_q, resp_wb_q;
  logic [way_bits-1:0] resp_way_q;
  logic [tag_bits-1:0] resp_wb_tag_q;

  logic [a_size-1:1]   plru_upd;
  logic [way_bits:0]   unode;
  logic [way_bits-1:0] upath;

  assign is_write = (op_q == 2'b01);

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      StInit: begin
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) state_d = StIdle;
      end
      StIdle: begin
        if (req_valid) begin
          if (req_op == 2'b10) begin
            state_d    = StInit;
            init_idx_d = '0;
          end else begin
            state_d = StLookup;
          end
        end
      end
      StLookup: state_d = StUpdate;
      StUpdate: state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StInit;
    endcase
  end

  // Tag compare and victim selection for the registered request.
  always_comb begin
    set_valid = valid_q[index_q];
    set_dirty = dirty_q[index_q];
    set_plru  = plru_q[index_q];
    lk_hit    = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = a_size - 1; w >= 0; w--) begin
      if (set_valid[w] && (tags_q[index_q][w] == tag_q)) begin
        lk_hit  = 1'b1;
        hit_way = way_bits'(w);
      end
      if (!set_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = way_bits'(w);
      end
    end
    node = {{way_bits{1'b0}}, 1'b1};
    for (int l = 0; l < way_bits; l++) begin
      node = {node[way_bits-1:0], set_plru[node[way_bits-1:0]]};
    end
    plru_way = node[way_bits-1:0];
    if (lk_hit)         lk_way = hit_way;
    else if (inv_found) lk_way = inv_way;
    else                lk_way = plru_way;
    lk_wb     = !lk_hit && set_valid[lk_way] && set_dirty[lk_way];
    lk_wb_tag = lk_wb ? tags_q[index_q][lk_way] : '0;
  end

  // Point every node on the path to the accessed way away from it.
  always_comb begin
    plru_upd = plru_q[index_q];
    unode    = {{way_bits{1'b0}}, 1'b1};
    upath    = lk_way_q;
    for (int l = 0; l < way_bits; l++) begin
      plru_upd[unode[way_bits-1:0]] = ~upath[way_bits-1];
      unode = {unode[way_bits-1:0], upath[way_bits-1]};
      upath = upath << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StInit;
      init_idx_q    <= '0;
      op_q          <= '0;
      tag_q         <= '0;
      index_q       <= '0;
      lk_hit_q      <= 1'b0;
      lk_wb_q       <= 1'b0;
      lk_way_q      <= '0;
      lk_wb_tag_q   <= '0;
      resp_hit_q    <= 1'b0;
      resp_wb_q     <= 1'b0;
      resp_way_q    <= '0;
      resp_wb_tag_q <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      if (req_valid && req_ready) begin
        op_q    <= req_op;
        tag_q   <= req_tag;
        index_q <= req_index;
      end
      if (state_q == StLookup) begin
        lk_hit_q    <= lk_hit;
        lk_wb_q     <= lk_wb;
        lk_way_q    <= lk_way;
        lk_wb_tag_q <= lk_wb_tag;
      end
      if (state_q == StUpdate) begin
        resp_hit_q    <= lk_hit_q;
        resp_wb_q     <= lk_wb_q;
        resp_way_q    <= lk_way_q;
        resp_wb_tag_q <= lk_wb_tag_q;
        if (lk_hit_q) begin
          if (hit_count != '1) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == StInit)) begin
      valid_q[init_idx_q] <= '0;
      dirty_q[init_idx_q] <= '0;
      plru_q[init_idx_q]  <= '0;
      for (int w = 0; w < a_size; w++) tags_q[init_idx_q][w] <= '0;
    end else if (!rst && (state_q == StUpdate)) begin
      if (!lk_hit_q) begin
        valid_q[index_q][lk_way_q] <= 1'b1;
        dirty_q[index_q][lk_way_q] <= is_write;
        tags_q[index_q][lk_way_q]  <= tag_q;
      end else if (is_write) begin
        dirty_q[index_q][lk_way_q] <= 1'b1;
      end
      plru_q[index_q] <= plru_upd;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = (state_q == StResp);
  assign resp_hit    = resp_valid & resp_hit_q;
  assign resp_wb     = resp_valid & resp_wb_q;
  assign resp_way    = resp_valid ? resp_way_q : '0;
  assign resp_wb_tag = resp_valid ? resp_wb_tag_q : '0;

endmodule
